id_hazard_unit: RTL and testbench
=================================

Name: id_hazard_unit

Overview:
- Hazard and forwarding controller that sits directly downstream of ID register select.
- Consumes the decoded source/destination register fields for the instruction in ID.
- Keeps its own registered shadow of destination writes in flight through EX, MEM and WB.
- Produces the ID stall/ready, the registered EX-stage forwarding selects, and a stall performance counter.

Parameters:
- ZERO_REG, 31: register index that is never a hazard source/target (XZR).
- CNT_W, 32: width of the saturating stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rf1  in  5  first source register
- id_rf1_used  in  1  first source is read
- id_rf2  in  5  second source register
- id_rf2_used  in  1  second source is read
- id_rd  in  5  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_memread  in  1  instruction is a load
- flush  in  1  taken branch resolved in EX; kill ID
- stall  out  1  hold PC and IF/ID, inject bubble into EX
- id_ready  out  1  equals !stall
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX operand B select, same encoding
- ex_valid  out  1  EX holds a non-bubble instruction
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow entries: EX, MEM, WB. Each holds {valid, rd, regwrite, memread}.
- An entry "writes r" when valid && regwrite && rd == r && r != ZERO_REG.
- Source match: a source matches only when its _used bit is 1 and id_valid is 1.
- Load-use hazard: EX entry valid && memread && writes a matching id_rf1 or id_rf2.
- stall is combinational: loaduse && !flush. No other cause stalls. flush masks stall.
- Update every cycle: WB<=MEM, MEM<=EX.
- EX<=ID fields when id_valid && !stall && !flush; otherwise EX<=bubble (valid 0).
- fwd_a/fwd_b are registered and loaded together with the EX entry, so they are valid in the cycle the consumer is in EX.
- fwd_a select, per source, evaluated from state in the ID cycle:
  - 10 if the EX entry writes the source (producer will be in MEM next cycle).
  - else 01 if the MEM entry writes the source.
  - else 00.
- fwd_b is computed the same way from id_rf2.
- WB-entry matches give 00. The register file provides write-through bypass, so they need no forwarding.
- An EX-entry load match never forwards, because it stalls instead.
- When EX is loaded with a bubble, fwd_a=fwd_b=00.
- ex_valid = EX.valid.
- stall_count increments by 1 on every cycle where stall=1 and saturates at all-ones.
- Reset (synchronous, highest priority, legal mid-operation):
  - Clears all entry valids and fields to 0.
  - fwd_a=fwd_b=00, stall_count=0, ex_valid=0.
  - stall therefore reads 0 in the cycle after reset.
- Latency: stall is same-cycle. fwd_a/fwd_b and ex_valid are one-cycle.
- A load-use stall lasts exactly one cycle. The load then sits in MEM and the consumer receives 01.

Decomposition:
- Shared cpu package holds:
  - ZERO_REG
  - Forward-select constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - A pipeline shadow-entry struct {valid, rd[4:0], regwrite, memread}
- One sub-module, hazard_fwd_sel: combinational per-source forwarding select from one source register plus the EX and MEM entries. It is instantiated twice, for A and B.

Test Plan:
- Dependent ALU pair, no load:
  - Stimulus: ADD X2 (rd=2, regwrite) in cycle 0; SUB with rf1=2, rf2=3 in cycle 1.
  - Required: stall=0, and fwd_a=10, fwd_b=00 in cycle 2.
- Load-use:
  - Stimulus: LDUR rd=1, memread=1 in cycle 0; ADD rf1=1 in cycle 1.
  - Required: stall=1 in cycle 1 only; ex_valid=0 in cycle 2; fwd_a=01 in cycle 3; stall_count=1.
- Zero register:
  - Stimulus: producer rd=31 regwrite; then consumer rf1=31 and rf2=31, both used.
  - Required: stall=0, fwd_a=fwd_b=00.
- CBZ/store after load:
  - Stimulus: LDUR rd=4; then CBZ rf1=4 (rf2_used=0).
  - Required: stall=1 for one cycle.
  - Stimulus: a STUR with rf2=4 and rf1=9 in the same position instead.
  - Required: stall=1, then fwd_b=01, fwd_a=00.
- Flush with hazard:
  - Stimulus: load-use condition present and flush=1 in the same cycle.
  - Required: stall=0, EX loaded as bubble (ex_valid=0 next cycle), stall_count unchanged.
- Reset mid-stream:
  - Stimulus: assert reset while a load is in EX and a dependent instruction is in ID.
  - Required: next cycle all outputs 0 and stall_count=0.
  - Stimulus: hold stall_count preloaded near max, then stall.
  - Required: stall_count saturates at all-ones.

Source files
------------

// File: rtl/id_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// id_hazard_unit_pkg
// Shared definitions for the ID-stage hazard / forwarding controller.
//   ZERO_REG      : register index that never creates a dependency (XZR)
//   FWD_*         : EX operand select encodings driven by the hazard unit
//   pipe_entry_t  : shadow copy of one in-flight instruction's write info
//   entry_writes  : "does this in-flight entry produce register r?"
// -----------------------------------------------------------------------------
package id_hazard_unit_pkg;

  localparam logic [4:0] ZERO_REG = 5'd31;

  // EX operand select: regfile, EX/MEM pipeline register, MEM/WB pipeline register
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } pipe_entry_t;

  localparam pipe_entry_t PIPE_BUBBLE = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0, memread: 1'b0};

  // An entry produces r only if it is live, writes a register, targets r,
  // and r is not the hardwired zero register.
  function automatic logic entry_writes(input pipe_entry_t e,
                                        input logic [4:0]  r,
                                        input logic [4:0]  zero_reg);
    return e.valid && e.regwrite && (e.rd == r) && (r != zero_reg);
  endfunction

endpackage

// File: rtl/id_hazard_unit_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forwarding decision for one source operand of the instruction
// currently in ID, evaluated against the EX / MEM / WB shadow entries.
// Ports:
//   src       in  5  source register index
//   src_en    in  1  source is actually read and ID holds a real instruction
//   ex_e      in     EX shadow entry
//   mem_e     in     MEM shadow entry
//   wb_e      in     WB shadow entry
//   fwd_sel   out 2  select to register for EX next cycle
//   load_hit  out 1  source depends on a load that is currently in EX
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import id_hazard_unit_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = id_hazard_unit_pkg::ZERO_REG
) (
  input  logic [4:0]  src,
  input  logic        src_en,
  input  pipe_entry_t ex_e,
  input  pipe_entry_t mem_e,
  input  pipe_entry_t wb_e,
  output logic [1:0]  fwd_sel,
  output logic        load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Match the source against each in-flight producer and pick the youngest one.
  always_comb begin
    ex_hit   = 1'b0;
    mem_hit  = 1'b0;
    wb_hit   = 1'b0;
    fwd_sel  = FWD_RF;
    load_hit = 1'b0;

    if (src_en) begin
      ex_hit  = entry_writes(ex_e,  src, ZERO_REG);
      mem_hit = entry_writes(mem_e, src, ZERO_REG);
      wb_hit  = entry_writes(wb_e,  src, ZERO_REG);
    end else begin
      ex_hit  = 1'b0;
      mem_hit = 1'b0;
      wb_hit  = 1'b0;
    end

    load_hit = ex_hit && ex_e.memread;

    if (ex_hit && !ex_e.memread) begin
      // ALU producer moves to MEM next cycle; take its EX/MEM result
      fwd_sel = FWD_EXMEM;
    end else if (ex_hit) begin
      // load data is not ready yet; the top stalls and EX gets a bubble
      fwd_sel = FWD_RF;
    end else if (mem_hit) begin
      fwd_sel = FWD_MEMWB;
    end else if (wb_hit) begin
      // regfile write-through bypass already delivers the WB value
      fwd_sel = FWD_RF;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// -----------------------------------------------------------------------------
// id_hazard_unit
// Hazard and forwarding controller sitting after ID register select. It keeps
// a registered shadow of destination writes in EX, MEM and WB, raises a
// one-cycle stall on load-use dependencies, and registers the EX operand
// forwarding selects alongside the instruction entering EX.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_rf1 / id_rf1_used        first source register and its read enable
//   id_rf2 / id_rf2_used        second source register and its read enable
//   id_rd / id_regwrite         destination register and its write enable
//   id_memread                  ID instruction is a load
//   flush                       taken branch in EX; ID instruction is killed
//   stall                       (comb) hold PC and IF/ID, bubble into EX
//   id_ready                    (comb) !stall
//   fwd_a / fwd_b               (reg) EX operand selects
//   ex_valid                    (reg) EX holds a non-bubble instruction
//   stall_count                 (reg) saturating count of stall cycles
// -----------------------------------------------------------------------------
module id_hazard_unit #(
  parameter logic [4:0]  ZERO_REG = id_hazard_unit_pkg::ZERO_REG,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rf1,
  input  logic             id_rf1_used,
  input  logic [4:0]       id_rf2,
  input  logic             id_rf2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             id_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_count
);

  import id_hazard_unit_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_entry_t      ex_q, ex_d;
  pipe_entry_t      mem_q, mem_d;
  pipe_entry_t      wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic       src1_en;
  logic       src2_en;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_hit_a;
  logic       load_hit_b;
  logic       stall_s;

  // Sources only count as dependencies when actually read by a real instruction.
  always_comb begin
    src1_en = id_valid && id_rf1_used;
    src2_en = id_valid && id_rf2_used;
  end

  hazard_fwd_sel #(
    .ZERO_REG (ZERO_REG)
  ) u_sel_a (
    .src      (id_rf1),
    .src_en   (src1_en),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .wb_e     (wb_q),
    .fwd_sel  (sel_a),
    .load_hit (load_hit_a)
  );

  hazard_fwd_sel #(
    .ZERO_REG (ZERO_REG)
  ) u_sel_b (
    .src      (id_rf2),
    .src_en   (src2_en),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .wb_e     (wb_q),
    .fwd_sel  (sel_b),
    .load_hit (load_hit_b)
  );

  // Load-use stall; a flush kills the consumer, so there is nothing to hold.
  always_comb begin
    stall_s = (load_hit_a || load_hit_b) && !flush;
  end

  // Next state of the shadow pipeline, forwarding selects and stall counter.
  always_comb begin
    ex_d          = PIPE_BUBBLE;
    fwd_a_d       = FWD_RF;
    fwd_b_d       = FWD_RF;
    mem_d         = ex_q;
    wb_d          = mem_q;
    stall_count_d = stall_count_q;

    if (id_valid && !stall_s && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      fwd_a_d       = sel_a;
      fwd_b_d       = sel_b;
    end else begin
      ex_d    = PIPE_BUBBLE;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end

    if (stall_s && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers; reset clears every entry and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= PIPE_BUBBLE;
      mem_q         <= PIPE_BUBBLE;
      wb_q          <= PIPE_BUBBLE;
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Output drive: stall/ready are same-cycle, the rest come straight from flops.
  always_comb begin
    stall       = stall_s;
    id_ready    = !stall_s;
    fwd_a       = fwd_a_q;
    fwd_b       = fwd_b_q;
    ex_valid    = ex_q.valid;
    stall_count = stall_count_q;
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed testbench for id_hazard_unit. A second instance with a 4-bit
// counter shares the stimulus and is used for the saturation check.
module tb_id_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rf1;
  logic        id_rf1_used;
  logic [4:0]  id_rf2;
  logic        id_rf2_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;

  logic        stall, id_ready, ex_valid;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count;

  logic        s_stall, s_id_ready, s_ex_valid;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_hazard_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rf1      (id_rf1),
    .id_rf1_used (id_rf1_used),
    .id_rf2      (id_rf2),
    .id_rf2_used (id_rf2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .id_ready    (id_ready),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .ex_valid    (ex_valid),
    .stall_count (stall_count)
  );

  id_hazard_unit #(.CNT_W(4)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rf1      (id_rf1),
    .id_rf1_used (id_rf1_used),
    .id_rf2      (id_rf2),
    .id_rf2_used (id_rf2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (s_stall),
    .id_ready    (s_id_ready),
    .fwd_a       (s_fwd_a),
    .fwd_b       (s_fwd_b),
    .ex_valid    (s_ex_valid),
    .stall_count (s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rf1      = r1;
    id_rf1_used = u1;
    id_rf2      = r2;
    id_rf2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ready", {31'd0, id_ready}, 32'd1);
    check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_count", stall_count, 32'd0);

    // Dependent ALU pair: ADD X2 then SUB rf1=2, rf2=3
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    check("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    check("alu_fwd_a", {30'd0, fwd_a}, 32'h2);
    check("alu_fwd_b", {30'd0, fwd_b}, 32'h0);
    check("alu_ex_valid", {31'd0, ex_valid}, 32'd1);
    drain();

    // Load-use: LDUR X1 then ADD rf1=1
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0);
    check("lu_stall_c1", {31'd0, stall}, 32'd1);
    check("lu_ready_c1", {31'd0, id_ready}, 32'd0);
    tick();
    check("lu_stall_c2", {31'd0, stall}, 32'd0);
    check("lu_ex_valid_c2", {31'd0, ex_valid}, 32'd0);
    check("lu_count_c2", stall_count, 32'd1);
    tick();
    idle();
    check("lu_fwd_a_c3", {30'd0, fwd_a}, 32'h1);
    check("lu_fwd_b_c3", {30'd0, fwd_b}, 32'h0);
    check("lu_ex_valid_c3", {31'd0, ex_valid}, 32'd1);
    check("lu_count_c3", stall_count, 32'd1);
    drain();

    // Zero register: load writing X31, then consumer reading X31 twice
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd3, 1'b1, 1'b0);
    check("xzr_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    check("xzr_fwd_a", {30'd0, fwd_a}, 32'h0);
    check("xzr_fwd_b", {30'd0, fwd_b}, 32'h0);
    drain();

    // CBZ after load: rf1=4 used, rf2=4 unused
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    check("cbz_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    check("cbz_stall_c2", {31'd0, stall}, 32'd0);
    tick();
    idle();
    check("cbz_fwd_a", {30'd0, fwd_a}, 32'h1);
    check("cbz_count", stall_count, 32'd2);
    drain();

    // Unused second source matching a load does not stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    check("unused_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    check("unused_fwd_b", {30'd0, fwd_b}, 32'h0);
    drain();

    // STUR after load: rf1=9, rf2=4
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    check("stur_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    check("stur_stall_c2", {31'd0, stall}, 32'd0);
    tick();
    idle();
    check("stur_fwd_a", {30'd0, fwd_a}, 32'h0);
    check("stur_fwd_b", {30'd0, fwd_b}, 32'h1);
    check("stur_count", stall_count, 32'd3);
    drain();

    // Invalid ID slot never stalls
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    check("novalid_stall", {31'd0, stall}, 32'd0);
    tick();
    check("novalid_ex_valid", {31'd0, ex_valid}, 32'd0);
    drain();

    // MEM forwarding and EX-over-MEM priority
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  // ADD X5
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);  // ADD X6
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);  // reads X5 (in MEM)
    tick();
    check("mem_fwd_a", {30'd0, fwd_a}, 32'h1);
    check("mem_fwd_b", {30'd0, fwd_b}, 32'h1);
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);  // ADD X6
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);  // ADD X6 again
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    check("prio_fwd_a", {30'd0, fwd_a}, 32'h2);
    check("prio_fwd_b", {30'd0, fwd_b}, 32'h0);
    drain();

    // Producer already in WB gives regfile select
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd22, 1'b1, 1'b0);
    tick();
    check("wb_fwd_a", {30'd0, fwd_a}, 32'h0);
    check("wb_fwd_b", {30'd0, fwd_b}, 32'h0);
    drain();

    // Flush together with a load-use hazard
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    idle();
    check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_count", stall_count, 32'd3);
    drain();

    // Reset mid-stream: load in EX, dependent in ID
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd12, 1'b1, 1'b0);
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mrst_stall", {31'd0, stall}, 32'd0);
    check("mrst_fwd_a", {30'd0, fwd_a}, 32'h0);
    check("mrst_fwd_b", {30'd0, fwd_b}, 32'h0);
    check("mrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("mrst_count", stall_count, 32'd0);
    check("mrst_sat_count", {28'd0, s_stall_count}, 32'd0);

    // Saturation: a self-dependent load repeated stalls every other cycle
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 27) check("sat_count_14", {28'd0, s_stall_count}, 32'd14);
      if (i == 29) check("sat_count_15", {28'd0, s_stall_count}, 32'd15);
    end
    check("sat_hold", {28'd0, s_stall_count}, 32'd15);
    check("wide_count_20", stall_count, 32'd20);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
